// File: rtl/pulse_regen.sv
// Regenerates single-cycle event pulses as fixed-width HIGH phases separated by a mandatory LOW gap.
// Events arriving mid-pulse are queued in a saturating counter; drops set a sticky overflow flag.
module pulse_regen #(
  parameter int HIGH_CYCLES = 3,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              ovf_clr,
  output logic              y,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAXC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0]     HLOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     LLOAD = CW'(LOW_CYCLES - 1);
  localparam logic [PEND_W-1:0] MAXP  = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [PEND_W-1:0] pend_n;
  logic              ovf_n, start, queue, drop;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start   = 1'b0;
    queue   = 1'b0;
    case (state)
      IDLE: begin
        // event is consumed directly; never touches the pending count
        if (pulse_in) begin
          state_n = HIGH;
          cnt_n   = HLOAD;
        end
      end
      HIGH: begin
        queue = pulse_in;
        if (cnt == '0) begin
          state_n = LOW;
          cnt_n   = LLOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      LOW: begin
        queue = pulse_in;
        if (cnt == '0) begin
          if (pending != '0 || pulse_in) begin
            start   = 1'b1;
            state_n = HIGH;
            cnt_n   = HLOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    pend_n = pending;
    drop   = 1'b0;
    if (queue && !start) begin
      if (pending == MAXP) drop = 1'b1;
      else                 pend_n = pending + 1'b1;
    end else if (start && !queue) begin
      pend_n = pending - 1'b1;
    end
    // a drop in the same cycle as a clear keeps the flag set
    ovf_n = drop | (overflow & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      y        <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pending  <= pend_n;
      overflow <= ovf_n;
      y        <= (state_n == HIGH);
      busy     <= (state_n != IDLE);
    end
  end

endmodule
